// File: rtl/hcsr04_meas_sequencer.sv
// HC-SR04 ranging sequencer: trigger pulse, echo width timing, timeout and repetition period.
// Single-shot or free-running; results are held for the register file.
module hcsr04_meas_sequencer #(
    parameter int unsigned CNT_W          = 24,
    parameter int unsigned TRIG_CYCLES    = 640,
    parameter int unsigned TIMEOUT_CYCLES = 2_560_000,
    parameter int unsigned PERIOD_CYCLES  = 4_160_000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_continuous,
    input  logic             i_single,
    input  logic             i_echo,
    output logic             o_trigger,
    output logic [CNT_W-1:0] o_width,
    output logic             o_valid,
    output logic             o_timeout,
    output logic             o_busy,
    output logic [2:0]       o_state
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StTrig     = 3'd1,
        StWaitRise = 3'd2,
        StMeasure  = 3'd3,
        StHoldoff  = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] TrigLast    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutFull = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] PeriodLast  = CNT_W'(PERIOD_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] width_out_d;
    logic [CNT_W-1:0] width_inc;
    logic             trig_d, valid_d, timeout_d;

    logic echo_meta_q, echo_sync_q, echo_dly_q;
    logic echo_rise, echo_fall;

    // Two-flop synchronizer plus one delay stage for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            echo_meta_q <= 1'b0;
            echo_sync_q <= 1'b0;
            echo_dly_q  <= 1'b0;
        end else begin
            echo_meta_q <= i_echo;
            echo_sync_q <= echo_meta_q;
            echo_dly_q  <= echo_sync_q;
        end
    end

    assign echo_rise = echo_sync_q & ~echo_dly_q;
    assign echo_fall = ~echo_sync_q & echo_dly_q;

    // The delayed copy lags by one cycle, so counting it over MEASURE plus the fall cycle
    // covers the same number of cycles the raw echo was high.
    assign width_inc = width_q + {{(CNT_W-1){1'b0}}, echo_dly_q};

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        period_d    = (period_q != PeriodLast) ? period_q + 1'b1 : period_q;
        width_d     = width_q;
        width_out_d = o_width;
        valid_d     = 1'b0;
        timeout_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                phase_d  = '0;
                period_d = '0;
                if (i_enable && (i_continuous || i_single)) begin
                    state_d = StTrig;
                end
            end
            StTrig: begin
                if (phase_q == TrigLast) begin
                    state_d = StWaitRise;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            StWaitRise: begin
                if (echo_rise) begin
                    state_d = StMeasure;
                    width_d = '0;
                end else if (phase_q == TimeoutLast) begin
                    state_d   = StHoldoff;
                    timeout_d = 1'b1;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            StMeasure: begin
                width_d = width_inc;
                if (echo_fall) begin
                    state_d     = StHoldoff;
                    width_out_d = width_inc;
                    valid_d     = 1'b1;
                end else if (width_inc == TimeoutFull) begin
                    state_d   = StHoldoff;
                    timeout_d = 1'b1;
                end
            end
            StHoldoff: begin
                if (period_q == PeriodLast) begin
                    if (i_enable && i_continuous) begin
                        state_d  = StTrig;
                        phase_d  = '0;
                        period_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Disable aborts the cycle without publishing any result.
        if (!i_enable && (state_q != StIdle)) begin
            state_d     = StIdle;
            width_out_d = o_width;
            valid_d     = 1'b0;
            timeout_d   = 1'b0;
        end

        trig_d = (state_d == StTrig);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            phase_q   <= '0;
            period_q  <= '0;
            width_q   <= '0;
            o_width   <= '0;
            o_trigger <= 1'b0;
            o_valid   <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            period_q  <= period_d;
            width_q   <= width_d;
            o_width   <= width_out_d;
            o_trigger <= trig_d;
            o_valid   <= valid_d;
            o_timeout <= timeout_d;
        end
    end

    assign o_busy  = (state_q != StIdle);
    assign o_state = state_q;

endmodule

// File: tb/tb_hcsr04_meas_sequencer.sv
// Directed bench for hcsr04_meas_sequencer with short trigger/timeout/period values.
module tb_hcsr04_meas_sequencer;

    localparam int unsigned CNT_W = 24;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable, continuous, single, echo;
    logic             trigger, valid, timeout, busy;
    logic [CNT_W-1:0] width;
    logic [2:0]       state;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_valid = 0;
    int n_timeout = 0;
    int bad_pulse = 0;
    logic prev_valid = 1'b0;
    logic prev_timeout = 1'b0;

    hcsr04_meas_sequencer #(
        .CNT_W          (CNT_W),
        .TRIG_CYCLES    (4),
        .TIMEOUT_CYCLES (50),
        .PERIOD_CYCLES  (100)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_enable     (enable),
        .i_continuous (continuous),
        .i_single     (single),
        .i_echo       (echo),
        .o_trigger    (trigger),
        .o_width      (width),
        .o_valid      (valid),
        .o_timeout    (timeout),
        .o_busy       (busy),
        .o_state      (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: counts result pulses and flags overlap or stretched pulses.
    always @(negedge clk) begin
        prev_valid   <= valid;
        prev_timeout <= timeout;
        if (valid) n_valid <= n_valid + 1;
        if (timeout) n_timeout <= n_timeout + 1;
        if ((valid && timeout) || (valid && prev_valid) || (timeout && prev_timeout))
            bad_pulse <= bad_pulse + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return trigger;
            1:       return valid;
            2:       return timeout;
            3:       return busy;
            default: return (state == 3'd3);
        endcase
    endfunction

    // Ticks until the selected signal equals val; n is the number of edges taken.
    task automatic wait_sig(input string tag, input int sel, input logic val, input int limit,
                            output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while ((sig(sel) !== val) && (n < limit));
        if (sig(sel) !== val) begin
            checks++;
            errors++;
            $error("FAIL %s observed=no_event expected=event_within_%0d", tag, limit);
        end
    endtask

    task automatic pulse_single();
        single = 1'b1;
    endtask

    initial begin
        int n;
        int t_rise;
        int v0;
        int t0;

        rst_n = 1'b0;
        enable = 1'b0;
        continuous = 1'b0;
        single = 1'b0;
        echo = 1'b0;
        #2;
        chk("rst_trigger", 32'(trigger), 32'd0);
        chk("rst_width", 32'(width), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // Single shot, echo 10 cycles after trigger fall, 20 cycles wide.
        enable = 1'b1;
        single = 1'b1;
        wait_sig("t1_trig_rise", 0, 1'b1, 10, n);
        single = 1'b0;
        t_rise = cyc;
        chk("t1_trig_start", 32'(n), 32'd1);
        wait_sig("t1_trig_fall", 0, 1'b0, 20, n);
        chk("t1_trig_len", 32'(n), 32'd4);
        chk("t1_state_wait", 32'(state), 32'd2);
        tick(10);
        echo = 1'b1;
        tick(20);
        echo = 1'b0;
        wait_sig("t1_valid", 1, 1'b1, 20, n);
        chk("t1_valid_lat", 32'(n), 32'd3);
        chk("t1_width", 32'(width), 32'd20);
        chk("t1_state_hold", 32'(state), 32'd4);
        tick(1);
        chk("t1_valid_once", 32'(valid), 32'd0);
        wait_sig("t1_idle", 3, 1'b0, 200, n);
        chk("t1_busy_span", 32'(cyc - t_rise), 32'd100);
        chk("t1_valid_cnt", 32'(n_valid), 32'd1);

        // Single shot, no echo at all.
        tick(3);
        v0 = n_valid;
        single = 1'b1;
        wait_sig("t2_trig_rise", 0, 1'b1, 10, n);
        single = 1'b0;
        wait_sig("t2_trig_fall", 0, 1'b0, 20, n);
        wait_sig("t2_timeout", 2, 1'b1, 100, n);
        chk("t2_timeout_lat", 32'(n), 32'd50);
        chk("t2_width_kept", 32'(width), 32'd20);
        chk("t2_no_valid", 32'(n_valid - v0), 32'd0);
        wait_sig("t2_idle", 3, 1'b0, 200, n);

        // Single shot, echo too long (80 cycles).
        tick(3);
        single = 1'b1;
        wait_sig("t3_trig_rise", 0, 1'b1, 10, n);
        single = 1'b0;
        wait_sig("t3_trig_fall", 0, 1'b0, 20, n);
        echo = 1'b1;
        wait_sig("t3_timeout", 2, 1'b1, 100, n);
        chk("t3_timeout_lat", 32'(n), 32'd53);
        tick(80 - n);
        echo = 1'b0;
        chk("t3_width_kept", 32'(width), 32'd20);
        chk("t3_no_valid", 32'(n_valid - v0), 32'd0);
        chk("t3_timeout_cnt", 32'(n_timeout), 32'd2);
        wait_sig("t3_idle", 3, 1'b0, 200, n);

        // Continuous mode, 15-cycle echo each shot.
        tick(3);
        continuous = 1'b1;
        wait_sig("t4_trig_rise0", 0, 1'b1, 10, n);
        t0 = cyc;
        for (int s = 0; s < 2; s++) begin
            wait_sig("t4_trig_fall", 0, 1'b0, 20, n);
            tick(10);
            echo = 1'b1;
            tick(15);
            echo = 1'b0;
            wait_sig("t4_valid", 1, 1'b1, 20, n);
            chk("t4_width", 32'(width), 32'd15);
            wait_sig("t4_trig_rise", 0, 1'b1, 200, n);
            chk("t4_spacing", 32'(cyc - t0), 32'd100);
            t0 = cyc;
        end
        continuous = 1'b0;
        wait_sig("t4_idle", 3, 1'b0, 300, n);

        // Drop enable during MEASURE, then restart with echo stuck high.
        tick(3);
        v0 = n_valid;
        single = 1'b1;
        wait_sig("t5_trig_rise", 0, 1'b1, 10, n);
        single = 1'b0;
        wait_sig("t5_trig_fall", 0, 1'b0, 20, n);
        tick(2);
        echo = 1'b1;
        wait_sig("t5_measure", 4, 1'b1, 20, n);
        chk("t5_measure_lat", 32'(n), 32'd3);
        tick(5);
        enable = 1'b0;
        tick(1);
        chk("t5_abort_state", 32'(state), 32'd0);
        chk("t5_abort_busy", 32'(busy), 32'd0);
        chk("t5_abort_trig", 32'(trigger), 32'd0);
        tick(3);
        chk("t5_abort_width", 32'(width), 32'd15);
        chk("t5_abort_novalid", 32'(n_valid - v0), 32'd0);
        enable = 1'b1;
        single = 1'b1;
        wait_sig("t5_restart", 0, 1'b1, 10, n);
        single = 1'b0;
        wait_sig("t5_trig_fall2", 0, 1'b0, 20, n);
        chk("t5_trig_len2", 32'(n), 32'd4);
        wait_sig("t5_stuck_timeout", 2, 1'b1, 100, n);
        chk("t5_stuck_lat", 32'(n), 32'd50);
        chk("t5_stuck_width", 32'(width), 32'd15);
        chk("t5_stuck_novalid", 32'(n_valid - v0), 32'd0);
        echo = 1'b0;
        wait_sig("t5_idle", 3, 1'b0, 200, n);

        // Async reset during TRIG.
        tick(3);
        single = 1'b1;
        wait_sig("t6_trig_rise", 0, 1'b1, 10, n);
        single = 1'b0;
        tick(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_trig", 32'(trigger), 32'd0);
        chk("t6_rst_state", 32'(state), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_width", 32'(width), 32'd0);
        chk("t6_rst_valid", 32'(valid), 32'd0);
        chk("t6_rst_timeout", 32'(timeout), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(5);
        chk("t6_no_restart", 32'(busy), 32'd0);
        chk("t6_trig_low", 32'(trigger), 32'd0);

        chk("pulse_shape", 32'(bad_pulse), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
